// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding register per functional unit,
// round-robin grant, registered broadcast and a saturating contention counter.
module cdb_arbiter #(
  parameter int N_REQ    = 4,
  parameter int CNT_W    = 16,
  parameter int RSV_ID_W = 6,
  parameter int DATA_W   = 32,
  localparam int CDB_W   = RSV_ID_W + DATA_W
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CDB_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   flush,
  output logic                   cdb_valid,
  output logic [CDB_W-1:0]       cdb,
  output logic [CNT_W-1:0]       contention_cnt
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [PTR_W:0]   N_REQ_EXT = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(N_REQ - 1);

  logic [N_REQ-1:0] hold_valid_q, hold_valid_d;
  logic [CDB_W-1:0] hold_data_q [N_REQ];
  logic [CDB_W-1:0] hold_data_d [N_REQ];
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic [CDB_W-1:0] cdb_q, cdb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] accept;
  logic             grant_any;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W:0]   scan;
  logic             seen_one;
  logic             multi_hold;

  // Scan from rr_ptr upward with an explicit modulo so non-power-of-two
  // requester counts never index past the last port.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      scan = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (scan >= N_REQ_EXT) scan = scan - N_REQ_EXT;
      if (!grant_any && hold_valid_q[scan[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan[PTR_W-1:0];
      end
    end
    if (nrst || flush) grant_any = 1'b0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    req_ready    = '0;
    accept       = '0;
    hold_valid_d = hold_valid_q;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i]    = ~nrst & ~flush & (~hold_valid_q[i] | grant[i]);
      accept[i]       = req_valid[i] & req_ready[i];
      hold_valid_d[i] = (hold_valid_q[i] & ~grant[i]) | accept[i];
      hold_data_d[i]  = accept[i] ? req_data[i*CDB_W +: CDB_W] : hold_data_q[i];
    end
    if (flush) hold_valid_d = '0;
  end

  always_comb begin
    cdb_valid_d = grant_any;
    cdb_d       = cdb_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    seen_one    = 1'b0;
    multi_hold  = 1'b0;
    if (grant_any) begin
      cdb_d    = hold_data_q[grant_idx];
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (hold_valid_q[i]) begin
        if (seen_one) multi_hold = 1'b1;
        seen_one = 1'b1;
      end
    end
    if (multi_hold && !flush && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      hold_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_q        <= '0;
      cnt_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_q        <= cdb_d;
      cnt_q        <= cnt_d;
    end
  end

  // Payloads need no reset: they are only observed behind hold_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      hold_data_q[i] <= hold_data_d[i];
    end
  end

  assign cdb_valid      = cdb_valid_q;
  assign cdb            = cdb_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter; a second instance with a 2-bit counter
// shares the stimulus to observe contention-counter saturation.
module tb_cdb_arbiter;

  localparam int N_REQ    = 4;
  localparam int RSV_ID_W = 6;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  logic                   clk;
  logic                   nrst;
  logic                   flush;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*CDB_W-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   cdb_valid;
  logic [CDB_W-1:0]       cdb;
  logic [15:0]            contention_cnt;
  logic [N_REQ-1:0]       sat_req_ready;
  logic                   sat_cdb_valid;
  logic [CDB_W-1:0]       sat_cdb;
  logic [1:0]             sat_cnt;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.N_REQ(N_REQ), .CNT_W(16), .RSV_ID_W(RSV_ID_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .flush(flush), .cdb_valid(cdb_valid), .cdb(cdb),
    .contention_cnt(contention_cnt)
  );

  cdb_arbiter #(.N_REQ(N_REQ), .CNT_W(2), .RSV_ID_W(RSV_ID_W), .DATA_W(DATA_W)) dut_sat (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(sat_req_ready), .flush(flush), .cdb_valid(sat_cdb_valid), .cdb(sat_cdb),
    .contention_cnt(sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] valid, input logic fl, input logic rst);
    req_valid = valid;
    flush     = fl;
    nrst      = rst;
  endtask

  task automatic setOffer(input int port, input int rob, input logic [DATA_W-1:0] data);
    req_data[port*CDB_W +: CDB_W] = {RSV_ID_W'(rob), data};
  endtask

  function automatic logic [63:0] bus(input int rob, input logic [DATA_W-1:0] data);
    return 64'({RSV_ID_W'(rob), data});
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    req_data = '0;
    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    checkOutput("reset_cdb", 64'(cdb), 64'd0);
    checkOutput("reset_cnt", 64'(contention_cnt), 64'd0);
    checkOutput("reset_ready", 64'(req_ready), 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    settle();
    checkOutput("idle_ready", 64'(req_ready), 64'hF);

    $display("[TB] single requester");
    setOffer(0, 3, 32'hDEAD_BEEF);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    settle();
    checkOutput("single_ready", 64'(req_ready), 64'hF);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("single_latency", 64'(cdb_valid), 64'd0);
    tick();
    checkOutput("single_valid", 64'(cdb_valid), 64'd1);
    checkOutput("single_cdb", 64'(cdb), bus(3, 32'hDEAD_BEEF));
    checkOutput("single_cnt", 64'(contention_cnt), 64'd0);
    tick();
    checkOutput("single_pulse", 64'(cdb_valid), 64'd0);
    checkOutput("single_cdb_hold", 64'(cdb), bus(3, 32'hDEAD_BEEF));

    applyStimulus(4'b0000, 1'b0, 1'b1);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);

    $display("[TB] round robin");
    for (int i = 0; i < N_REQ; i++) setOffer(i, i, 32'h1000_0000 + DATA_W'(i));
    applyStimulus(4'b1111, 1'b0, 1'b0);
    settle();
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("rr_latency", 64'(cdb_valid), 64'd0);
    for (int i = 0; i < N_REQ; i++) begin
      tick();
      checkOutput("rr_valid", 64'(cdb_valid), 64'd1);
      checkOutput("rr_cdb", 64'(cdb), bus(i, 32'h1000_0000 + DATA_W'(i)));
    end
    tick();
    checkOutput("rr_idle", 64'(cdb_valid), 64'd0);
    checkOutput("rr_cnt", 64'(contention_cnt), 64'd3);
    checkOutput("rr_sat_cnt", 64'(sat_cnt), 64'd3);

    $display("[TB] fairness");
    setOffer(0, 10, 32'hA000_0000);
    setOffer(2, 20, 32'hC000_0000);
    applyStimulus(4'b0101, 1'b0, 1'b0);
    settle();
    tick();
    setOffer(0, 11, 32'hA000_0001);
    applyStimulus(4'b0001, 1'b0, 1'b0);
    settle();
    checkOutput("fair_ready_a", 64'(req_ready), 64'hB);
    tick();
    checkOutput("fair_cdb_p0a", 64'(cdb), bus(10, 32'hA000_0000));
    setOffer(0, 12, 32'hA000_0002);
    settle();
    checkOutput("fair_ready_b", 64'(req_ready), 64'hE);
    tick();
    checkOutput("fair_valid_p2", 64'(cdb_valid), 64'd1);
    checkOutput("fair_cdb_p2", 64'(cdb), bus(20, 32'hC000_0000));
    tick();
    checkOutput("fair_cdb_p0b", 64'(cdb), bus(11, 32'hA000_0001));
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("fair_cdb_p0c", 64'(cdb), bus(12, 32'hA000_0002));
    tick();
    checkOutput("fair_idle", 64'(cdb_valid), 64'd0);
    checkOutput("fair_cnt", 64'(contention_cnt), 64'd5);
    checkOutput("sat_cnt_stop", 64'(sat_cnt), 64'd3);

    $display("[TB] back-to-back port 1");
    setOffer(1, 5, 32'hB000_0005);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    settle();
    checkOutput("b2b_ready_0", 64'(req_ready), 64'hF);
    tick();
    setOffer(1, 6, 32'hB000_0006);
    settle();
    checkOutput("b2b_ready_1", 64'(req_ready), 64'hF);
    tick();
    checkOutput("b2b_cdb_5", 64'(cdb), bus(5, 32'hB000_0005));
    setOffer(1, 7, 32'hB000_0007);
    settle();
    checkOutput("b2b_ready_2", 64'(req_ready), 64'hF);
    tick();
    checkOutput("b2b_cdb_6", 64'(cdb), bus(6, 32'hB000_0006));
    applyStimulus(4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("b2b_valid_7", 64'(cdb_valid), 64'd1);
    checkOutput("b2b_cdb_7", 64'(cdb), bus(7, 32'hB000_0007));
    tick();
    checkOutput("b2b_idle", 64'(cdb_valid), 64'd0);

    $display("[TB] flush");
    setOffer(0, 30, 32'hF000_0000);
    setOffer(1, 31, 32'hF000_0001);
    setOffer(2, 32, 32'hF000_0002);
    applyStimulus(4'b0111, 1'b0, 1'b0);
    settle();
    tick();
    setOffer(3, 33, 32'hF000_0003);
    applyStimulus(4'b1000, 1'b1, 1'b0);
    settle();
    checkOutput("flush_ready", 64'(req_ready), 64'd0);
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("flush_valid", 64'(cdb_valid), 64'd0);
    checkOutput("flush_cdb_hold", 64'(cdb), bus(7, 32'hB000_0007));
    checkOutput("flush_cnt", 64'(contention_cnt), 64'd5);
    settle();
    checkOutput("flush_cleared", 64'(req_ready), 64'hF);
    tick();
    checkOutput("flush_no_bcast_a", 64'(cdb_valid), 64'd0);
    tick();
    checkOutput("flush_no_bcast_b", 64'(cdb_valid), 64'd0);

    $display("[TB] reset mid-stream");
    setOffer(0, 40, 32'hE000_0000);
    setOffer(1, 41, 32'hE000_0001);
    applyStimulus(4'b0011, 1'b0, 1'b0);
    settle();
    tick();
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("mid_latency", 64'(cdb_valid), 64'd0);
    tick();
    checkOutput("mid_cdb", 64'(cdb), bus(40, 32'hE000_0000));
    checkOutput("mid_cnt", 64'(contention_cnt), 64'd6);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    settle();
    checkOutput("mid_reset_ready", 64'(req_ready), 64'd0);
    tick();
    checkOutput("mid_reset_valid", 64'(cdb_valid), 64'd0);
    checkOutput("mid_reset_cdb", 64'(cdb), 64'd0);
    checkOutput("mid_reset_cnt", 64'(contention_cnt), 64'd0);
    checkOutput("mid_reset_sat_cnt", 64'(sat_cnt), 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    settle();
    checkOutput("mid_dropped_ready", 64'(req_ready), 64'hF);
    tick();
    checkOutput("mid_dropped_valid", 64'(cdb_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbiter and scheduler for the common data bus (CDB) shared by the fcpu functional units. Each execution unit (ALU, MUL, LSU, …) offers one completed result per cycle as {rob_id, data}. The block buffers each offer in a one-entry holding register, grants the bus to one holder per cycle in round-robin order, and drives the registered `cdb_valid`/`cdb` pair that every reservation station and the ROB snoop for operand wake-up.

## Interface
Parameters:
- `N_REQ`, 4, number of requesting functional units (2..8)
- `CNT_W`, 16, width of the contention counter

Ports:
- `clk`  in  1  clock
- `nrst`  in  1  reset, synchronous, active-high (asserted when `nrst`=1)
- `req_valid`  in  N_REQ  result offer per requester
- `req_data`  in  N_REQ*CDB_W  per-requester {rob_id[RSV_ID_W], data[DATA_W]}; requester i occupies bits [i*CDB_W +: CDB_W]; widths from fcpu_pkg
- `req_ready`  out  N_REQ  offer accepted this cycle when `req_valid[i]` & `req_ready[i]`
- `flush`  in  1  pipeline flush; discards all buffered and pending broadcasts
- `cdb_valid`  out  1  broadcast valid
- `cdb`  out  CDB_W  broadcast {rob_id, data}; same layout as `req_data`
- `contention_cnt`  out  CNT_W  saturating count of cycles where more than one holder was waiting

## Operation
- State: `hold_valid[N_REQ]`, `hold_data[N_REQ]`, round-robin pointer `rr_ptr` ($clog2(N_REQ) bits), output registers `cdb_valid`/`cdb`, and `contention_cnt`.
- Grant (combinational): the first i with `hold_valid[i]`=1, scanning from `rr_ptr` upward modulo N_REQ. At most one grant per cycle. No grant when no holder is valid.
- On a grant to w at the clock edge:
  - `cdb` <= `hold_data[w]`, `cdb_valid` <= 1.
  - `hold_valid[w]` is cleared unless it is refilled in the same cycle.
  - `rr_ptr` <= (w+1) mod N_REQ.
- With no grant: `cdb_valid` <= 0, `cdb` holds its value, `rr_ptr` is unchanged.
- `req_ready[i]` = ~nrst & ~flush & (~hold_valid[i] | grant[i]). A holder being granted accepts a new offer in the same cycle, so one port sustains one result per cycle.
- Accept: `hold_data[i]` <= `req_data[i]`, `hold_valid[i]` <= 1.
- Flush, registered effect:
  - all `hold_valid` <= 0 and `cdb_valid` <= 0; no grant is issued in a flush cycle.
  - `rr_ptr` and `contention_cnt` are kept.
  - `req_ready` = 0 during the flush cycle.
- `contention_cnt` increments when popcount(`hold_valid`) >= 2 and there is no flush. It saturates at 2^CNT_W-1 and does not wrap.
- Data of a non-granted holder is never modified.
- Requesters must hold `req_valid`/`req_data` stable until accepted. The block does not check this.

## Timing
- Reset (`nrst`=1 at an edge): `cdb_valid`=0, `cdb`=0, `hold_valid`=0, `rr_ptr`=0, `contention_cnt`=0. `req_ready`=0 combinationally while `nrst`=1.
- Reset mid-operation: pending holders are dropped with no broadcast.
- Latency: accept at edge k → held after k → granted and broadcast after edge k+1 when uncontended (2 cycles from `req_valid` to `cdb_valid`).
- Worst-case wait for a valid holder: N_REQ-1 grants, which gives starvation freedom.
- Throughput: one broadcast per cycle whenever any holder is valid.
- `cdb_valid` is high for exactly one cycle per broadcast. Consumers must sample it every cycle; there is no backpressure on the CDB.
- Simultaneous events:
  - flush + accept: flush wins, nothing is accepted.
  - nrst + flush: reset wins.
  - grant + refill on the same port: the old value is broadcast and the new value is held.
- `rr_ptr` wrap: a grant at N_REQ-1 sets `rr_ptr`=0. For N_REQ not a power of two, the pointer never takes values ≥ N_REQ.

## Test plan
- Single requester: after reset, `req_valid[0]`=1 with {rob 3, 0xDEAD_BEEF} for one cycle → `req_ready[0]`=1; `cdb_valid`=1 with {3, 0xDEADBEEF} two cycles later for exactly one cycle; `contention_cnt`=0.
- Round-robin: all 4 ports offer in the same cycle with rob ids 0..3, `rr_ptr`=0 → broadcasts of rob 0,1,2,3 in consecutive cycles; `contention_cnt`=3; `rr_ptr` ends at 0.
- Fairness: port 0 offers every cycle and port 2 offers once → port 2 is broadcast within 2 cycles of being held, and port 0 is interleaved afterwards.
- Back-to-back one port: port 1 offers rob 5,6,7 in consecutive cycles → `req_ready[1]` stays 1; broadcasts 5,6,7 in consecutive cycles.
- Flush: ports 0–2 hold results and `flush` is pulsed → the next cycle has `cdb_valid`=0, all holders are cleared, and no discarded rob id is ever broadcast; `req_ready`=0 during the flush cycle.
- Reset mid-stream and saturation: assert `nrst` with holders valid → all outputs return to reset values on the next edge. With CNT_W=2 and 5 contended cycles → `contention_cnt` stops at 3.
